// File: rtl/traffic_light_ctrl.sv
// Single-intersection traffic-light controller with a pedestrian phase and a tick prescaler.
// Optional night mode (forced yellow blinking) is built when TLC_NIGHT_MODE_EN is defined.
module traffic_light_ctrl #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int CNT_W         = 8,
    parameter int T_GREEN       = 15,
    parameter int T_GREEN_MIN   = 5,
    parameter int T_GREEN_BLINK = 6,
    parameter int T_YELLOW      = 4,
    parameter int T_RED         = 11,
    parameter int T_RED_YELLOW  = 6,
    parameter int T_WALK        = 11,
    parameter int BLINK_HALF    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
`ifdef TLC_NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       walk,
    output logic       req_pending,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_YELLOW       = 3'd0,
        S_YELLOW_BLINK = 3'd1,
        S_GREEN        = 3'd2,
        S_GREEN_BLINK  = 3'd3,
        S_RED          = 3'd4,
        S_RED_YELLOW   = 3'd5,
        S_WALK         = 3'd6
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PW-1:0]    PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(32'd1);
    localparam logic [BW-1:0]    BC_MAX     = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0]    BC_ONE     = BW'(32'd1);
    localparam logic [CNT_W-1:0] PC_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] G_MIN_LAST = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GB_LAST    = CNT_W'(T_GREEN_BLINK - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] RY_LAST    = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] W_LAST     = CNT_W'(T_WALK - 1);

    logic [PW-1:0]    presc_r;
    logic             tick_s;
    logic [2:0]       state_r;
    state_t           state_nx_s;
    logic             change_s;
    logic [CNT_W-1:0] pc_r, pc_nx_s;
    logic             blink_r, blink_nx_s;
    logic [BW-1:0]    bc_r, bc_nx_s;
    logic             req_r, req_nx_s;
    logic [2:0]       btn_sync_r;
    logic             press_s;
    logic             night_s;
    logic             in_blink_s;

`ifdef TLC_NIGHT_MODE_EN
    logic [1:0] night_sync_r;

    // Two-flop synchroniser for the asynchronous night request.
    always_ff @(posedge clk) begin
        if (reset) begin
            night_sync_r <= 2'b00;
        end else begin
            night_sync_r <= {night_sync_r[0], night};
        end
    end
    assign night_s = night_sync_r[1];
`else
    assign night_s = 1'b0;
`endif

    // Tick prescaler: wraps at TICK_DIV-1, tick marks the wrap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end
    assign tick_s = (presc_r == PRESC_MAX);

    // Button is active-low; the third stage turns a held press into a single pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_r <= 3'b000;
        end else begin
            btn_sync_r <= {btn_sync_r[1:0], ~button};
        end
    end
    assign press_s = btn_sync_r[1] & ~btn_sync_r[2];

    // Next-state decision; every timed transition waits for a tick, code 7 recovers at once.
    always_comb begin
        state_nx_s = S_YELLOW_BLINK;
        if (tick_s && night_s) begin
            state_nx_s = S_YELLOW_BLINK;
        end else begin
            case (state_r)
                S_YELLOW_BLINK: state_nx_s = tick_s ? S_GREEN : S_YELLOW_BLINK;
                S_GREEN: begin
                    if (tick_s && ((pc_r == G_LAST) || (req_r && (pc_r >= G_MIN_LAST)))) begin
                        state_nx_s = S_GREEN_BLINK;
                    end else begin
                        state_nx_s = S_GREEN;
                    end
                end
                S_GREEN_BLINK:  state_nx_s = (tick_s && (pc_r == GB_LAST)) ? S_YELLOW : S_GREEN_BLINK;
                S_YELLOW:       state_nx_s = (tick_s && (pc_r == Y_LAST)) ? S_RED : S_YELLOW;
                S_RED: begin
                    if (tick_s && req_r) begin
                        state_nx_s = S_WALK;
                    end else if (tick_s && (pc_r == R_LAST)) begin
                        state_nx_s = S_RED_YELLOW;
                    end else begin
                        state_nx_s = S_RED;
                    end
                end
                S_WALK:         state_nx_s = (tick_s && (pc_r == W_LAST)) ? S_RED_YELLOW : S_WALK;
                S_RED_YELLOW:   state_nx_s = (tick_s && (pc_r == RY_LAST)) ? S_GREEN : S_RED_YELLOW;
                default:        state_nx_s = S_YELLOW_BLINK;
            endcase
        end
    end

    assign change_s   = (state_nx_s != state_r);
    assign in_blink_s = (state_r == S_YELLOW_BLINK) || (state_r == S_GREEN_BLINK);

    // Phase counter, blink phase and request latch updates.
    always_comb begin
        pc_nx_s    = pc_r;
        blink_nx_s = blink_r;
        bc_nx_s    = bc_r;
        req_nx_s   = req_r;
        if (change_s) begin
            pc_nx_s    = {CNT_W{1'b0}};
            blink_nx_s = 1'b1;
            bc_nx_s    = {BW{1'b0}};
        end else if (tick_s) begin
            pc_nx_s = pc_r + PC_ONE;
            if (in_blink_s && (bc_r == BC_MAX)) begin
                blink_nx_s = ~blink_r;
                bc_nx_s    = {BW{1'b0}};
            end else if (in_blink_s) begin
                bc_nx_s = bc_r + BC_ONE;
            end else begin
                bc_nx_s = bc_r;
            end
        end else begin
            pc_nx_s = pc_r;
        end
        // WALK entry wins over a coincident press, which is therefore dropped.
        if (change_s && (state_nx_s == S_WALK)) begin
            req_nx_s = 1'b0;
        end else if (tick_s && night_s) begin
            req_nx_s = 1'b0;
        end else if (press_s && (state_r != S_WALK) && (state_r != S_YELLOW_BLINK)) begin
            req_nx_s = 1'b1;
        end else begin
            req_nx_s = req_r;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_YELLOW_BLINK;
            pc_r    <= {CNT_W{1'b0}};
            blink_r <= 1'b1;
            bc_r    <= {BW{1'b0}};
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            blink_r <= blink_nx_s;
            bc_r    <= bc_nx_s;
            req_r   <= req_nx_s;
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        lamp_red    = 1'b0;
        lamp_yellow = 1'b0;
        lamp_green  = 1'b0;
        walk        = 1'b0;
        case (state_r)
            S_YELLOW:       lamp_yellow = 1'b1;
            S_YELLOW_BLINK: lamp_yellow = blink_r;
            S_GREEN:        lamp_green  = 1'b1;
            S_GREEN_BLINK:  lamp_green  = blink_r;
            S_RED:          lamp_red    = 1'b1;
            S_RED_YELLOW: begin
                lamp_red    = 1'b1;
                lamp_yellow = 1'b1;
            end
            S_WALK: begin
                lamp_red = 1'b1;
                walk     = 1'b1;
            end
            default: lamp_red = 1'b0;
        endcase
    end

    assign req_pending = req_r;
    assign state       = state_r;

endmodule
